// File: rtl/ifm_fetch_pkg.sv
// Shared types and constants for the IFM fetch controller.
package ifm_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/ifm_fetch_fifo.sv
// Two-entry show-ahead FIFO carrying {last, data}; head is valid whenever not empty.
module ifm_fetch_fifo
  import ifm_fetch_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Next-state: a push into a full FIFO is only legal alongside a pop, and then
  // it overwrites the slot being popped this same cycle.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + 2'(push) - 2'(pop);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// IFM BRAM read initiator: walks a num_rows x row_words tile in raster order,
// issues single-cycle reads and streams the returned words out over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for start, cfg_* sampled on start
//   FETCH | issuing reads while no more than two words are owed
//   DRAIN | all reads issued, waiting for the last word to be accepted
//   DONE  | one-cycle done pulse, then back to IDLE
module ifm_fetch_ctrl
  import ifm_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]     cfg_row_words,
  input  logic [CNT_WIDTH-1:0]     cfg_num_rows,
  input  logic [ADDRESS_WIDTH-1:0] cfg_row_stride,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ifm_address,
  output logic                     ifm_address_valid,
  output logic                     write_en,
  output logic [DATA_WIDTH-1:0]    data_in,
  input  logic [DATA_WIDTH-1:0]    ifm_out,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam int PW = 2 * CNT_WIDTH;

  fetch_state_e           state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] row_start_q, row_start_d;
  logic [ADDRESS_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]   row_words_q, row_words_d;
  logic [CNT_WIDTH-1:0]   col_left_q, col_left_d;
  logic [PW-1:0]          words_left_q, words_left_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_last_q, inflight_last_d;

  logic [PW-1:0]          tile_words;
  logic [DATA_WIDTH:0]    fifo_head;
  logic                   fifo_empty;
  logic [1:0]             fifo_count;
  logic                   pop;
  logic                   issue;
  logic [2:0]             owed;

  assign tile_words = PW'(cfg_row_words) * PW'(cfg_num_rows);
  assign pop        = !fifo_empty && m_ready;
  assign owed       = {1'b0, fifo_count} + {2'b00, inflight_q};
  // A slot freed by this cycle's pop may be reused by this cycle's read; that
  // is what keeps one word per cycle flowing with m_ready held high.
  assign issue      = (state_q == FETCH) && (owed < (3'd2 + {2'b00, pop}));

  // Sequencing, address walk and word accounting.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    row_start_d     = row_start_q;
    stride_d        = stride_q;
    row_words_d     = row_words_q;
    col_left_d      = col_left_q;
    words_left_d    = words_left_q;
    inflight_d      = issue;
    inflight_last_d = issue && (words_left_q == PW'(1));
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = cfg_base_addr;
          row_start_d  = cfg_base_addr;
          stride_d     = cfg_row_stride;
          row_words_d  = cfg_row_words;
          col_left_d   = cfg_row_words;
          words_left_d = tile_words;
          state_d      = (tile_words == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          words_left_d = words_left_q - PW'(1);
          if (col_left_q == CNT_WIDTH'(1)) begin
            row_start_d = row_start_q + stride_q;
            addr_d      = row_start_q + stride_q;
            col_left_d  = row_words_q;
          end else begin
            addr_d      = addr_q + ADDRESS_WIDTH'(WORD_BYTES);
            col_left_d  = col_left_q - CNT_WIDTH'(1);
          end
          if (words_left_q == PW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_head[DATA_WIDTH]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == FETCH) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= '0;
      row_start_q     <= '0;
      stride_q        <= '0;
      row_words_q     <= '0;
      col_left_q      <= '0;
      words_left_q    <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      addr_q          <= addr_d;
      row_start_q     <= row_start_d;
      stride_q        <= stride_d;
      row_words_q     <= row_words_d;
      col_left_q      <= col_left_d;
      words_left_q    <= words_left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  ifm_fetch_fifo #(
    .W(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({inflight_last_q, ifm_out}),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign busy              = busy_q;
  assign done              = done_q;
  assign ifm_address       = addr_q;
  assign ifm_address_valid = issue;
  assign write_en          = 1'b0;
  assign data_in           = '0;
  assign m_valid           = !fifo_empty;
  assign m_data            = fifo_head[DATA_WIDTH-1:0];
  assign m_last            = !fifo_empty && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Bench for ifm_fetch_ctrl: BRAM model, raster-order reference model and
// per-cycle output compare, directed tiles plus randomized tiles and backpressure.
module tb_ifm_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_row_words;
  logic [15:0] cfg_num_rows;
  logic [31:0] cfg_row_stride;
  logic        busy, done;
  logic [31:0] ifm_address;
  logic        ifm_address_valid;
  logic        write_en;
  logic [31:0] data_in;
  logic [31:0] ifm_out;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  always #5 clk = ~clk;

  ifm_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_row_words    (cfg_row_words),
    .cfg_num_rows     (cfg_num_rows),
    .cfg_row_stride   (cfg_row_stride),
    .busy             (busy),
    .done             (done),
    .ifm_address      (ifm_address),
    .ifm_address_valid(ifm_address_valid),
    .write_en         (write_en),
    .data_in          (data_in),
    .ifm_out          (ifm_out),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_last           (m_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // BRAM contents as a function of word index; garbage when no read was issued.
  function automatic logic [31:0] bram_f(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    ifm_out <= ifm_address_valid ? bram_f(ifm_address) : $urandom();
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: 0 = always, 1 = random, 2 = held low inside [stall_lo, stall_hi)
  int rmode   = 0;
  int stall_lo = 0;
  int stall_hi = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       m_ready = ($urandom_range(0, 3) != 0);
        2:       m_ready = !(cyc >= stall_lo && cyc < stall_hi);
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Reference model state
  logic [31:0] exp_addr[$];
  logic [32:0] exp_word[$];
  bit          active_m = 0;
  bit          done_now = 0;
  int          issued = 0;
  int          accepted = 0;
  int          max_owed = 0;
  bit          prev_stall = 0;
  logic [32:0] prev_word = '0;

  // Observation for directed literal checks
  logic [31:0] obs_addr[$];
  int first_issue_cyc, last_issue_cyc, first_mv_cyc, first_hs_cyc, last_hs_cyc;
  int hs_cnt, last_cnt;

  task automatic clear_obs();
    obs_addr.delete();
    first_issue_cyc = -1;
    last_issue_cyc  = -1;
    first_mv_cyc    = -1;
    first_hs_cyc    = -1;
    last_hs_cyc     = -1;
    hs_cnt          = 0;
    last_cnt        = 0;
    max_owed        = 0;
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit          done_nxt;
    bit          was_active;
    logic [32:0] w;
    logic [31:0] a;
    int          rw, nr;
    if (rst) begin
      exp_addr.delete();
      exp_word.delete();
      active_m   = 0;
      done_now   = 0;
      issued     = 0;
      accepted   = 0;
      prev_stall = 0;
    end else begin
      was_active = active_m;
      done_nxt   = 0;
      chk("done", 64'(done), 64'(done_now));
      chk("busy", 64'(busy), 64'(active_m));
      chk("write_en", 64'(write_en), 64'(0));
      chk("data_in", 64'(data_in), 64'(0));
      if (ifm_address_valid) begin
        issued++;
        obs_addr.push_back(ifm_address);
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        if (exp_addr.size() == 0) chk("unexpected_read", 64'(1), 64'(0));
        else chk("ifm_address", 64'(ifm_address), 64'(exp_addr.pop_front()));
      end
      if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
      if (prev_stall) begin
        chk("m_valid_hold", 64'(m_valid), 64'(1));
        chk("m_data_hold", 64'({m_last, m_data}), 64'(prev_word));
      end
      if (m_valid && m_ready) begin
        accepted++;
        hs_cnt++;
        if (m_last) last_cnt++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (exp_word.size() == 0) chk("spurious_word", 64'(1), 64'(0));
        else begin
          w = exp_word.pop_front();
          chk("m_word", 64'({m_last, m_data}), 64'(w));
          if (w[32]) begin
            active_m = 0;
            done_nxt = 1;
          end
        end
      end
      if (issued - accepted > max_owed) max_owed = issued - accepted;
      chk("outstanding_le_2", 64'((issued - accepted) <= 2), 64'(1));
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
      if (!was_active && !done_now && start) begin
        rw = int'(cfg_row_words);
        nr = int'(cfg_num_rows);
        if (rw * nr == 0) done_nxt = 1;
        else begin
          active_m = 1;
          for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < rw; c++) begin
              a = cfg_base_addr + cfg_row_stride * 32'(r) + 32'(4 * c);
              exp_addr.push_back(a);
              exp_word.push_back({(r == nr - 1) && (c == rw - 1), bram_f(a)});
            end
          end
        end
      end
      done_now = done_nxt;
    end
  end

  task automatic wait_done();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 3000) chk("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_tile(input logic [31:0] b, input logic [15:0] rw, input logic [15:0] nr,
                          input logic [31:0] st, input bit poke);
    @(posedge clk);
    #1;
    cfg_base_addr  = b;
    cfg_row_words  = rw;
    cfg_num_rows   = nr;
    cfg_row_stride = st;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (poke && (int'(rw) * int'(nr) != 0)) begin
      @(posedge clk);
      #1;
      cfg_base_addr  = $urandom() & 32'hFFFF_FFFC;
      cfg_row_words  = 16'($urandom_range(1, 3));
      cfg_num_rows   = 16'd1;
      start          = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done();
    chk("addr_queue_drained", 64'(exp_addr.size()), 64'(0));
    chk("word_queue_drained", 64'(exp_word.size()), 64'(0));
  endtask

  task automatic chk_addrs(input logic [31:0] e [8], input int n);
    chk("addr_count", 64'(obs_addr.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < obs_addr.size()) chk("addr_list", 64'(obs_addr[i]), 64'(e[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e [8];
    rst            = 1'b1;
    start          = 1'b0;
    cfg_base_addr  = '0;
    cfg_row_words  = '0;
    cfg_num_rows   = '0;
    cfg_row_stride = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_av", 64'(ifm_address_valid), 64'(0));
    chk("rst_addr", 64'(ifm_address), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Single row, full throughput
    clear_obs();
    run_tile(32'h0, 16'd4, 16'd1, 32'h0, 0);
    e = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0};
    chk_addrs(e, 4);
    chk("t1_issue_span", 64'(last_issue_cyc - first_issue_cyc), 64'(3));
    chk("t1_mvalid_latency", 64'(first_mv_cyc - first_issue_cyc), 64'(2));
    chk("t1_handshake_span", 64'(last_hs_cyc - first_hs_cyc), 64'(3));
    chk("t1_words", 64'(hs_cnt), 64'(4));
    chk("t1_last_count", 64'(last_cnt), 64'(1));

    // Multi-row with stride
    clear_obs();
    run_tile(32'h10, 16'd2, 16'd3, 32'h20, 0);
    e = '{32'h10, 32'h14, 32'h30, 32'h34, 32'h50, 32'h54, 32'h0, 32'h0};
    chk_addrs(e, 6);
    chk("t2_words", 64'(hs_cnt), 64'(6));
    chk("t2_last_count", 64'(last_cnt), 64'(1));

    // Ten cycles of backpressure mid-tile
    clear_obs();
    rmode    = 2;
    stall_lo = cyc + 6;
    stall_hi = stall_lo + 10;
    run_tile(32'h100, 16'd4, 16'd4, 32'h40, 0);
    rmode = 0;
    chk("t3_words", 64'(hs_cnt), 64'(16));
    chk("t3_max_outstanding", 64'(max_owed), 64'(2));

    // Empty tiles issue nothing
    clear_obs();
    run_tile(32'h40, 16'd0, 16'd3, 32'h4, 0);
    run_tile(32'h40, 16'd5, 16'd0, 32'h4, 0);
    chk("t4_no_reads", 64'(obs_addr.size()), 64'(0));
    chk("t4_no_words", 64'(hs_cnt), 64'(0));

    // Start while busy is ignored
    clear_obs();
    run_tile(32'h200, 16'd3, 16'd2, 32'h10, 1);
    e = '{32'h200, 32'h204, 32'h208, 32'h210, 32'h214, 32'h218, 32'h0, 32'h0};
    chk_addrs(e, 6);

    // Address wrap
    clear_obs();
    run_tile(32'hFFFF_FFFC, 16'd2, 16'd1, 32'h0, 0);
    e = '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    chk_addrs(e, 2);

    // Reset in the middle of FETCH
    @(posedge clk);
    #1;
    cfg_base_addr  = 32'h0;
    cfg_row_words  = 16'd8;
    cfg_num_rows   = 16'd1;
    cfg_row_stride = 32'h0;
    start          = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_av", 64'(ifm_address_valid), 64'(0));
    chk("midrst_addr", 64'(ifm_address), 64'(0));
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    chk("midrst_m_last", 64'(m_last), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_obs();
    run_tile(32'h10, 16'd2, 16'd3, 32'h20, 0);
    e = '{32'h10, 32'h14, 32'h30, 32'h34, 32'h50, 32'h54, 32'h0, 32'h0};
    chk_addrs(e, 6);
    chk("post_rst_words", 64'(hs_cnt), 64'(6));

    // Randomized tiles under random backpressure
    rmode = 1;
    for (int t = 0; t < 16; t++) begin
      logic [31:0] b;
      b = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFF0;
      run_tile(b, 16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)),
               32'($urandom_range(0, 64)) * 32'd4, 1'($urandom_range(0, 1)));
    end
    rmode = 0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
